// File: rtl/idx_stream_pkg.sv
// Shared widths and types for the index-stream receive path.
package idx_stream_pkg;

    localparam int DATA_W = 128;
    localparam int IDX_W  = $clog2(DATA_W);
    localparam int CNT_W  = $clog2(DATA_W + 1);

    typedef enum logic {ACCUM, FLUSH} dec_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  count;
        logic              dup;
        logic              range;
    } idx_frame_t;

endpackage

// File: rtl/idx_onehot_dec.sv
// Combinational index to one-hot decoder; out-of-range indices decode to all zeros.
module idx_onehot_dec
    import idx_stream_pkg::*;
(
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] onehot,
    output logic              in_range
);

    // When the frame fills the whole index space every index is legal.
    if (DATA_W == (1 << IDX_W)) begin : g_full
        assign in_range = 1'b1;
    end else begin : g_partial
        assign in_range = (int'(idx) < DATA_W);
    end

    assign onehot = in_range ? ({{(DATA_W-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/idx_stream_decoder.sv
// Rebuilds frames from a stream of set-bit indices and hands them out over valid/ready.
module idx_stream_decoder
    import idx_stream_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic              in_null,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_dup,
    output logic              out_range
);

    dec_state_t        state;
    idx_frame_t        acc;
    idx_frame_t        acc_nxt;
    idx_frame_t        out_q;
    logic [DATA_W-1:0] onehot;
    logic              idx_in_range;
    logic              accept;
    logic              slot_free;

    idx_onehot_dec u_onehot_dec (
        .idx      (in_idx),
        .onehot   (onehot),
        .in_range (idx_in_range)
    );

    assign accept    = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;

    // Accumulator as it would look after folding in the current beat.
    always_comb begin
        // NOTE: default assignment first so every path drives acc_nxt and no latch is inferred.
        acc_nxt = acc;
        if (!in_null) begin
            if (!idx_in_range) begin
                acc_nxt.range = 1'b1;
            end else if ((acc.data & onehot) != '0) begin
                acc_nxt.dup = 1'b1;
            end else begin
                acc_nxt.data  = acc.data | onehot;
                acc_nxt.count = acc.count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the output register is reset too, so a frame held at reset is never presented.
            state     <= ACCUM;
            in_ready  <= 1'b0;
            acc       <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (in_last && slot_free) begin
                            out_q     <= acc_nxt;
                            out_valid <= 1'b1;
                            acc       <= '0;
                        end else if (in_last) begin
                            // Output still held: park the finished frame until it drains.
                            acc      <= acc_nxt;
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                        end else begin
                            acc <= acc_nxt;
                        end
                    end
                end
                FLUSH: begin
                    if (slot_free) begin
                        out_q     <= acc;
                        out_valid <= 1'b1;
                        acc       <= '0;
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign out_data  = out_q.data;
    assign out_count = out_q.count;
    assign out_dup   = out_q.dup;
    assign out_range = out_q.range;

endmodule

// File: tb/tb_idx_stream_decoder.sv
// Directed bench for idx_stream_decoder with a frame-level reference model and scoreboard.
module tb_idx_stream_decoder;
    import idx_stream_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IDX_W-1:0]  in_idx = '0;
    logic              in_null = 1'b0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_dup;
    logic              out_range;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                count;
        bit                dup;
        bit                range;
    } exp_frame_t;

    exp_frame_t        exp_q[$];
    logic [DATA_W-1:0] m_bits  = '0;
    bit                m_dup   = 1'b0;
    bit                m_range = 1'b0;

    idx_stream_decoder dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_null   (in_null),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_dup   (out_dup),
        .out_range (out_range)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [159:0] actual, input logic [159:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input int idx, input bit is_null, input bit is_last);
        int waited;
        in_valid = 1'b1;
        in_idx   = IDX_W'(idx);
        in_null  = is_null;
        in_last  = is_last;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("beat_in_ready", 160'(in_ready), 160'(1));
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_null  = 1'b0;
        in_last  = 1'b0;
    endtask

    // Reference model and scoreboard, evaluated mid-cycle when everything is settled.
    logic [DATA_W-1:0] held_data;
    logic [CNT_W-1:0]  held_count;
    bit                held_stall = 1'b0;

    always @(negedge clock) begin
        exp_frame_t f;
        if (!reset) begin
            m_bits     = '0;
            m_dup      = 1'b0;
            m_range    = 1'b0;
            held_stall = 1'b0;
        end else begin
            if (held_stall) begin
                check("stall_valid", 160'(out_valid), 160'(1));
                check("stall_data", 160'(out_data), 160'(held_data));
                check("stall_count", 160'(out_count), 160'(held_count));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 160'(1), 160'(0));
                end else begin
                    f = exp_q.pop_front();
                    check("sb_data", 160'(out_data), 160'(f.data));
                    check("sb_count", 160'(out_count), 160'(f.count));
                    check("sb_dup", 160'(out_dup), 160'(f.dup));
                    check("sb_range", 160'(out_range), 160'(f.range));
                end
            end
            held_stall = out_valid && !out_ready;
            held_data  = out_data;
            held_count = out_count;
            if (in_valid && in_ready) begin
                if (!in_null) begin
                    if (int'(in_idx) >= DATA_W) m_range = 1'b1;
                    else if (m_bits[in_idx]) m_dup = 1'b1;
                    else m_bits[in_idx] = 1'b1;
                end
                if (in_last) begin
                    f.data  = m_bits;
                    f.count = $countones(m_bits);
                    f.dup   = m_dup;
                    f.range = m_range;
                    exp_q.push_back(f);
                    m_bits  = '0;
                    m_dup   = 1'b0;
                    m_range = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] exp_k;

        // Reset state.
        tick();
        check("rst_in_ready", 160'(in_ready), 160'(0));
        check("rst_out_valid", 160'(out_valid), 160'(0));
        check("rst_out_data", 160'(out_data), 160'(0));
        reset = 1'b1;
        tick();
        check("post_rst_in_ready", 160'(in_ready), 160'(1));

        // 1: beats 3,5,127
        out_ready = 1'b1;
        beat(3, 0, 0);
        beat(5, 0, 0);
        beat(127, 0, 1);
        idle();
        check("t1_valid", 160'(out_valid), 160'(1));
        check("t1_data", 160'(out_data), 160'(128'h8000_0000_0000_0000_0000_0000_0000_0028));
        check("t1_count", 160'(out_count), 160'(3));
        check("t1_dup", 160'(out_dup), 160'(0));
        check("t1_range", 160'(out_range), 160'(0));
        tick();
        check("t1_valid_fall", 160'(out_valid), 160'(0));

        // 2: repeated index
        beat(9, 0, 0);
        beat(9, 0, 1);
        idle();
        check("t2_data", 160'(out_data), 160'(128'h200));
        check("t2_count", 160'(out_count), 160'(1));
        check("t2_dup", 160'(out_dup), 160'(1));
        tick();

        // 3: back-pressure forces FLUSH
        out_ready = 1'b0;
        beat(1, 0, 1);
        beat(2, 0, 1);
        idle();
        check("t3_in_ready_flush", 160'(in_ready), 160'(0));
        check("t3_a_valid", 160'(out_valid), 160'(1));
        check("t3_a_data", 160'(out_data), 160'(128'h2));
        tick();
        check("t3_a_held", 160'(out_data), 160'(128'h2));
        out_ready = 1'b1;
        tick();
        check("t3_b_valid", 160'(out_valid), 160'(1));
        check("t3_b_data", 160'(out_data), 160'(128'h4));
        check("t3_b_count", 160'(out_count), 160'(1));
        check("t3_in_ready_back", 160'(in_ready), 160'(1));
        tick();
        check("t3_valid_fall", 160'(out_valid), 160'(0));

        // 4: empty frame
        beat(0, 1, 1);
        idle();
        check("t4_valid", 160'(out_valid), 160'(1));
        check("t4_data", 160'(out_data), 160'(0));
        check("t4_count", 160'(out_count), 160'(0));
        tick();
        check("t4_valid_fall", 160'(out_valid), 160'(0));

        // 5: reset mid-frame
        beat(1, 0, 0);
        beat(2, 0, 0);
        idle();
        reset = 1'b0;
        tick();
        tick();
        check("t5_rst_in_ready", 160'(in_ready), 160'(0));
        check("t5_rst_valid", 160'(out_valid), 160'(0));
        reset = 1'b1;
        tick();
        check("t5_ready_again", 160'(in_ready), 160'(1));
        beat(4, 0, 1);
        idle();
        check("t5_data", 160'(out_data), 160'(128'h10));
        check("t5_count", 160'(out_count), 160'(1));
        check("t5_dup", 160'(out_dup), 160'(0));
        tick();

        // 6: 64 single-beat frames back to back
        for (int k = 0; k < 64; k++) begin
            in_valid = 1'b1;
            in_idx   = IDX_W'(k);
            in_null  = 1'b0;
            in_last  = 1'b1;
            tick();
            exp_k = '0;
            exp_k[k] = 1'b1;
            check("t6_valid", 160'(out_valid), 160'(1));
            check("t6_data", 160'(out_data), 160'(exp_k));
        end
        idle();
        tick();
        check("t6_valid_fall", 160'(out_valid), 160'(0));
        tick();
        check("sb_drained", 160'(exp_q.size()), 160'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
